hazard_controller: RTL
======================

Name: hazard_controller

Overview:
- Pipeline sequencing controller for the 5-stage LEGv8 pipelined CPU.
- Works alongside the forwarding unit. Handles the hazards forwarding cannot cover:
  - load-use stalls
  - EX-stage branch flushes
  - multi-cycle data-memory waits, with a timeout fault
- Drives the PC and pipeline-register enables, flushes and bubbles.

Parameters:
- MEM_TIMEOUT, 16: maximum consecutive wait cycles before FAULT; legal range 1..255.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- MemRead_ex  in  1  instruction in EX is a load
- Rd_ex  in  5  destination register of the EX instruction
- regA_id, regB_id  in  5  source registers of the ID instruction
- useA_id, useB_id  in  1  ID instruction actually reads regA_id / regB_id
- BrTaken_ex  in  1  branch in EX resolved taken
- dmem_req_mem  in  1  MEM stage is issuing a load or store
- dmem_ready  in  1  data memory completes the access this cycle
- PCWrite  out  1  PC register enable
- IFID_Write  out  1  IF/ID register enable
- IFID_Flush  out  1  IF/ID is loaded with a NOP
- IDEX_Bubble  out  1  ID/EX is loaded with a NOP
- EXMEM_Write  out  1  EX/MEM register enable
- MEMWB_Bubble  out  1  MEM/WB is loaded with a NOP
- mem_fault  out  1  sticky memory-timeout flag
- stall_count  out  32  load-use stall cycles (optional feature)
- flush_count  out  32  branch flushes (optional feature)

Behaviour:
- FSM states: RUN, MEM_WAIT, FAULT. The state and wait counter wait_cnt are the only registers, apart from the optional counters.
- Reset (reset_n low, asynchronous): state = RUN, wait_cnt = 0, mem_fault = 0, counters = 0.
- All control outputs are combinational from the current state and inputs. They take effect on the same clock edge, i.e. zero latency.
- Default (no hazard): PCWrite = IFID_Write = EXMEM_Write = 1; IFID_Flush = IDEX_Bubble = MEMWB_Bubble = 0.
- Load-use hazard (lu) = MemRead_ex && Rd_ex != 31 && ((useA_id && regA_id == Rd_ex) || (useB_id && regB_id == Rd_ex)).
  - X31 (XZR) is never a hazard.
- Memory wait (mw) = dmem_req_mem && !dmem_ready.
- Priority, highest first: FAULT > mw > BrTaken_ex > lu.
- FAULT:
  - PCWrite = IFID_Write = EXMEM_Write = 0, MEMWB_Bubble = 1, mem_fault = 1.
  - Exit only via reset.
- mw (RUN or MEM_WAIT):
  - Freeze: PCWrite = IFID_Write = EXMEM_Write = 0, IDEX_Bubble = 0 (ID/EX holds), MEMWB_Bubble = 1.
  - Branch and load-use actions are deferred, not lost: inputs are held stable by the freeze and re-evaluated after release.
- BrTaken_ex (not mw):
  - IFID_Flush = 1, IDEX_Bubble = 1, PCWrite = 1 (the PC loads the target).
  - A simultaneous lu is ignored because its consumer is squashed.
- lu only: PCWrite = 0, IFID_Write = 0, IDEX_Bubble = 1 for exactly one cycle.
  - The next cycle the load is in MEM and forwarding handles the value.
- Transitions:
  - RUN -> MEM_WAIT when mw; wait_cnt <= 1.
  - MEM_WAIT with mw and wait_cnt < MEM_TIMEOUT: stay; wait_cnt <= wait_cnt + 1.
  - MEM_WAIT with mw and wait_cnt == MEM_TIMEOUT: go to FAULT; mem_fault rises on that edge.
  - MEM_WAIT with dmem_ready: outputs are released in that same cycle; go to RUN; wait_cnt <= 0.
  - dmem_req_mem dropping while in MEM_WAIT is treated as completion: go to RUN.
- Boundaries:
  - MEM_TIMEOUT = 1 faults after 2 consecutive not-ready cycles: 1 cycle entering MEM_WAIT, then 1 more.
  - wait_cnt never wraps.
  - dmem_ready high in the first request cycle causes no stall.
- Reset asserted mid-stall returns to RUN immediately, outputs at default.

Optional Feature:
- HAZARD_STATS_EN defined:
  - stall_count increments on each cycle where lu is acted on (lu && !mw && !BrTaken_ex && state != FAULT).
  - flush_count increments on each acted-on BrTaken_ex.
  - Both saturate at 0xFFFFFFFF and are cleared by reset.
- Undefined: both ports are tied to 0 and no counter flops exist.

Test Plan:
- Load-use on regA: MemRead_ex = 1, Rd_ex = 5, regA_id = 5, useA_id = 1 -> PCWrite = 0, IFID_Write = 0, IDEX_Bubble = 1 for one cycle; stall_count = 1 (stats on).
- XZR and unused sources: Rd_ex = 31, regA_id = 31; then Rd_ex = 7, regB_id = 7, useB_id = 0 -> no stall either case.
- Branch with load-use: BrTaken_ex = 1 together with lu -> IFID_Flush = 1, IDEX_Bubble = 1, PCWrite = 1; flush_count = 1, stall_count unchanged.
- Memory wait: dmem_req_mem = 1, dmem_ready = 0 for 3 cycles, then 1 -> freeze outputs for 3 cycles, released in cycle 4; state RUN in cycle 5; mem_fault = 0.
- Timeout (MEM_TIMEOUT = 4): ready held low -> mem_fault = 1 after the 5th not-ready edge; stays 1 with ready high; cleared only by reset_n = 0.
- Async reset mid MEM_WAIT: reset_n low between edges -> outputs at default immediately; wait_cnt = 0; counters = 0.

Source files
------------

// File: rtl/hazard_controller.sv
// Hazard sequencing for the 5-stage LEGv8 pipeline: load-use stalls, EX branch flushes, data-memory waits with timeout.
// Define HAZARD_STATS_EN to build the saturating stall/flush event counters; otherwise both count ports read 0.
module hazard_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        MemRead_ex,
    input  logic [4:0]  Rd_ex,
    input  logic [4:0]  regA_id,
    input  logic [4:0]  regB_id,
    input  logic        useA_id,
    input  logic        useB_id,
    input  logic        BrTaken_ex,
    input  logic        dmem_req_mem,
    input  logic        dmem_ready,
    output logic        PCWrite,
    output logic        IFID_Write,
    output logic        IFID_Flush,
    output logic        IDEX_Bubble,
    output logic        EXMEM_Write,
    output logic        MEMWB_Bubble,
    output logic        mem_fault,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] waitCnt;

    logic loadUse;
    logic memWait;
    logic inFault;
    logic stallActed;
    logic flushActed;

    // XZR reads as zero, so a load targeting X31 never creates a dependency.
    assign loadUse = MemRead_ex && (Rd_ex != 5'd31) &&
                     ((useA_id && (regA_id == Rd_ex)) || (useB_id && (regB_id == Rd_ex)));
    assign memWait = dmem_req_mem && !dmem_ready;
    assign inFault = (state == FAULT);

    assign stallActed = loadUse && !memWait && !BrTaken_ex && !inFault;
    assign flushActed = BrTaken_ex && !memWait && !inFault;

    assign mem_fault = inFault;

    always_comb begin
        PCWrite      = 1'b1;
        IFID_Write   = 1'b1;
        EXMEM_Write  = 1'b1;
        IFID_Flush   = 1'b0;
        IDEX_Bubble  = 1'b0;
        MEMWB_Bubble = 1'b0;
        if (inFault) begin
            PCWrite      = 1'b0;
            IFID_Write   = 1'b0;
            EXMEM_Write  = 1'b0;
            MEMWB_Bubble = 1'b1;
        end else if (memWait) begin
            // ID/EX holds rather than bubbling so a deferred branch or load-use re-evaluates intact.
            PCWrite      = 1'b0;
            IFID_Write   = 1'b0;
            EXMEM_Write  = 1'b0;
            MEMWB_Bubble = 1'b1;
        end else if (BrTaken_ex) begin
            IFID_Flush  = 1'b1;
            IDEX_Bubble = 1'b1;
        end else if (loadUse) begin
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= RUN;
            waitCnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (memWait) begin
                        state   <= MEM_WAIT;
                        waitCnt <= CNT_ONE;
                    end else begin
                        waitCnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    // A dropped request counts as completion, same as ready.
                    if (!memWait) begin
                        state   <= RUN;
                        waitCnt <= '0;
                    end else if (waitCnt >= TIMEOUT_VAL) begin
                        state <= FAULT;
                    end else begin
                        waitCnt <= waitCnt + CNT_ONE;
                    end
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: begin
                    state   <= RUN;
                    waitCnt <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stallActed && (stall_count != 32'hFFFF_FFFF)) begin
                stall_count <= stall_count + 32'd1;
            end
            if (flushActed && (flush_count != 32'hFFFF_FFFF)) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`else
    logic unusedStats;
    assign unusedStats = stallActed ^ flushActed;
    assign stall_count = 32'd0;
    assign flush_count = 32'd0;
`endif

endmodule
